condlogic_banked: RTL and testbench

- Parametrised successor to the multi-cycle conditional-execution unit.
- Holds the architectural flag register with a configurable number of flags and independent write groups.
- Evaluates the 4-bit ARM condition code and latches the result only on an explicit controller strobe.
- Adds a LIFO flag-save stack for exception entry/return (push on entry, pop on return), with full/empty/error status. Gates PCWrite/RegWrite/MemWrite for the multi-cycle controller.

---
 rtl/condlogic_banked_if.sv | 48 ++++
 rtl/condlogic_banked.sv | 154 +++++++++++++++
 tb/tb_condlogic_banked.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/condlogic_banked_if.sv
// condlogic_banked_if
//   Bus between the multi-cycle controller/decoder and the conditional
//   execution unit.
//   master : controller side, drives condition, flag-write, write-request
//            and stack strobes; observes gated writes, condition and status.
//   slave  : condlogic_banked side.
//   Parameters NFLAGS / NGRP must match the attached condlogic_banked.
interface condlogic_banked_if #(
    parameter int NFLAGS = 4,
    parameter int NGRP   = 2
);
    // controller -> unit
    logic [3:0]        Cond;
    logic [NFLAGS-1:0] ALUFlags;
    logic [NGRP-1:0]   FlagW;
    logic              CondLatch;
    logic              PCS;
    logic              NextPC;
    logic              RegW;
    logic              MemW;
    logic              FlagPush;
    logic              FlagPop;

    // unit -> controller
    logic              PCWrite;
    logic              RegWrite;
    logic              MemWrite;
    logic              CondEx;
    logic              CondExQ;
    logic [NFLAGS-1:0] Flags;
    logic              StackEmpty;
    logic              StackFull;
    logic              StackErr;

    modport master (
        output Cond, ALUFlags, FlagW, CondLatch, PCS, NextPC, RegW, MemW,
               FlagPush, FlagPop,
        input  PCWrite, RegWrite, MemWrite, CondEx, CondExQ, Flags,
               StackEmpty, StackFull, StackErr
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, CondLatch, PCS, NextPC, RegW, MemW,
               FlagPush, FlagPop,
        output PCWrite, RegWrite, MemWrite, CondEx, CondExQ, Flags,
               StackEmpty, StackFull, StackErr
    );
endinterface

// File: rtl/condlogic_banked.sv
// condlogic_banked
//   Conditional-execution unit for a multi-cycle ARM-style core.
//   - Flag register (NFLAGS bits, [3:0] = N,Z,C,V) written in NGRP
//     independent groups, each only when the current instruction passes
//     its condition.
//   - ARM condition evaluation (CondEx, combinational) and a latched copy
//     (CondExQ) captured on the controller's CondLatch strobe.
//   - LIFO flag-save stack (DEPTH entries) for exception entry/return,
//     with empty/full status and a sticky misuse error.
//   - Gates PCWrite / RegWrite / MemWrite with the latched condition.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : condlogic_banked_if.slave (all controller-facing signals)
module condlogic_banked #(
    parameter int NFLAGS = 4,
    parameter int NGRP   = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    condlogic_banked_if.slave bus
);

    localparam int GW = NFLAGS / NGRP;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [NFLAGS-1:0] flags;
    logic [NFLAGS-1:0] flags_next;
    logic              cond_ex;
    logic              cond_exq;
    logic [CW-1:0]     count;
    logic              stack_err;
    logic [NFLAGS-1:0] stack_mem [DEPTH];

    logic              n_flag, z_flag, c_flag, v_flag;
    logic              empty, full;
    logic              push_only, pop_only, push_pop;
    logic              do_push, do_pop, err_event;
    logic [IW-1:0]     push_idx, pop_idx;

    assign n_flag = flags[3];
    assign z_flag = flags[2];
    assign c_flag = flags[1];
    assign v_flag = flags[0];

    // ------------------------------------------------------------------
    // Condition check, always on the registered flags
    // ------------------------------------------------------------------
    always_comb begin
        cond_ex = 1'b1;
        case (bus.Cond)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            default: cond_ex = 1'b1;  // AL, and 1111 treated as always
        endcase
    end

    // ------------------------------------------------------------------
    // Stack control
    // ------------------------------------------------------------------
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);

    assign push_only = bus.FlagPush & ~bus.FlagPop;
    assign pop_only  = bus.FlagPop & ~bus.FlagPush;
    assign push_pop  = bus.FlagPush & bus.FlagPop;

    assign do_push   = push_only & ~full;
    assign do_pop    = pop_only & ~empty;
    // Simultaneous push+pop is ambiguous, so it is flagged and ignored.
    assign err_event = (push_only & full) | (pop_only & empty) | push_pop;

    // Index truncation is safe: push only when count < DEPTH, pop only
    // when count >= 1.
    assign push_idx  = IW'(count);
    assign pop_idx   = IW'(count - CW'(1));

    // ------------------------------------------------------------------
    // Next flag value: group writes first, then a pop overrides them
    // ------------------------------------------------------------------
    always_comb begin
        flags_next = flags;
        for (int unsigned g = 0; g < NGRP; g++) begin
            if (bus.FlagW[g] && cond_ex) begin
                flags_next[g*GW +: GW] = bus.ALUFlags[g*GW +: GW];
            end
        end
        if (do_pop) begin
            flags_next = stack_mem[pop_idx];
        end
    end

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags     <= '0;
            cond_exq  <= 1'b0;
            count     <= '0;
            stack_err <= 1'b0;
        end else begin
            flags <= flags_next;
            if (bus.CondLatch) begin
                cond_exq <= cond_ex;
            end
            if (do_push) begin
                count <= count + CW'(1);
            end else if (do_pop) begin
                count <= count - CW'(1);
            end
            if (err_event) begin
                stack_err <= 1'b1;
            end
        end
    end

    // Stack storage needs no reset; entries above count are never read.
    // The pushed value is the pre-update flag register.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[push_idx] <= flags;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.CondEx     = cond_ex;
    assign bus.CondExQ    = cond_exq;
    assign bus.Flags      = flags;
    assign bus.PCWrite    = bus.PCS | (bus.NextPC & cond_exq);
    assign bus.RegWrite   = bus.RegW & cond_exq;
    assign bus.MemWrite   = bus.MemW & cond_exq;
    assign bus.StackEmpty = empty;
    assign bus.StackFull  = full;
    assign bus.StackErr   = stack_err;

endmodule

// File: tb/tb_condlogic_banked.sv
// tb_condlogic_banked
//   Directed bench for condlogic_banked (NFLAGS=4, NGRP=2, DEPTH=4).
//   Group 0 = Flags[1:0] (C,V), group 1 = Flags[3:2] (N,Z).
module tb_condlogic_banked;

    localparam int NFLAGS = 4;
    localparam int NGRP   = 2;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    condlogic_banked_if #(.NFLAGS(NFLAGS), .NGRP(NGRP)) bus ();

    condlogic_banked #(
        .NFLAGS(NFLAGS),
        .NGRP  (NGRP),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.Cond      = 4'h0;
        bus.ALUFlags  = '0;
        bus.FlagW     = '0;
        bus.CondLatch = 1'b0;
        bus.PCS       = 1'b0;
        bus.NextPC    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.FlagPush  = 1'b0;
        bus.FlagPop   = 1'b0;
    endtask

    task automatic load_flags(input logic [3:0] v);
        bus.Cond     = 4'hE;
        bus.FlagW    = 2'b11;
        bus.ALUFlags = v;
        step();
        bus.FlagW    = 2'b00;
    endtask

    // exp_vec[c] is the hand-derived CondEx for condition code c
    task automatic cond_table(input string tag, input logic [15:0] exp_vec);
        for (int i = 0; i < 16; i++) begin
            bus.Cond = 4'(i);
            #1;
            check($sformatf("%s_cond%0d", tag, i), 32'(bus.CondEx),
                  32'(exp_vec[i]));
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b0;
        #2;
        check("rst_flags", 32'(bus.Flags), 32'h0);
        check("rst_condexq", 32'(bus.CondExQ), 32'h0);
        check("rst_empty", 32'(bus.StackEmpty), 32'h1);
        check("rst_full", 32'(bus.StackFull), 32'h0);
        check("rst_err", 32'(bus.StackErr), 32'h0);
        check("rst_pcwrite", 32'(bus.PCWrite), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // EQ on zero flags fails; latched result blocks RegWrite
        bus.Cond = 4'h0;
        #1;
        check("eq_zero_condex", 32'(bus.CondEx), 32'h0);
        bus.CondLatch = 1'b1;
        bus.RegW      = 1'b1;
        step();
        bus.CondLatch = 1'b0;
        check("latch_fail_q", 32'(bus.CondExQ), 32'h0);
        check("regwrite_blocked", 32'(bus.RegWrite), 32'h0);
        bus.NextPC = 1'b1;
        #1;
        check("nextpc_blocked", 32'(bus.PCWrite), 32'h0);
        bus.PCS = 1'b1;
        #1;
        check("pcs_uncond", 32'(bus.PCWrite), 32'h1);
        idle();

        // AL flag write, then EQ passes and enables writes
        load_flags(4'b0100);
        check("al_write", 32'(bus.Flags), 32'h4);
        bus.Cond = 4'h0;
        #1;
        check("eq_pass_condex", 32'(bus.CondEx), 32'h1);
        bus.CondLatch = 1'b1;
        step();
        bus.CondLatch = 1'b0;
        check("latch_pass_q", 32'(bus.CondExQ), 32'h1);
        bus.MemW   = 1'b1;
        bus.RegW   = 1'b1;
        bus.NextPC = 1'b1;
        #1;
        check("memwrite_en", 32'(bus.MemWrite), 32'h1);
        check("regwrite_en", 32'(bus.RegWrite), 32'h1);
        check("nextpc_en", 32'(bus.PCWrite), 32'h1);
        idle();

        // Failed condition suppresses flag write; partial group write
        load_flags(4'b0000);
        bus.Cond     = 4'h0;
        bus.FlagW    = 2'b11;
        bus.ALUFlags = 4'hF;
        step();
        check("cond_fail_nowrite", 32'(bus.Flags), 32'h0);
        bus.Cond  = 4'hE;
        bus.FlagW = 2'b10;
        step();
        check("group1_only", 32'(bus.Flags), 32'hC);
        idle();

        // Condition table on three flag patterns
        cond_table("f1100", 16'hEA99);
        load_flags(4'b0011);
        idle();
        cond_table("f0011", 16'hE966);
        load_flags(4'b1001);
        idle();
        cond_table("f1001", 16'hD65A);

        // Push with same-cycle group write, then pop overriding FlagW
        load_flags(4'b1010);
        bus.FlagPush = 1'b1;
        bus.FlagW    = 2'b11;
        bus.ALUFlags = 4'b0101;
        step();
        check("push_flagw_applies", 32'(bus.Flags), 32'h5);
        check("push_not_empty", 32'(bus.StackEmpty), 32'h0);
        bus.FlagPush = 1'b0;
        bus.FlagPop  = 1'b1;
        bus.ALUFlags = 4'b1111;
        step();
        check("pop_wins", 32'(bus.Flags), 32'hA);
        check("pop_empty", 32'(bus.StackEmpty), 32'h1);
        check("pop_no_err", 32'(bus.StackErr), 32'h0);
        idle();

        // Fill: pushed values are pre-update flags A,1,2,3
        for (int i = 0; i < DEPTH; i++) begin
            bus.Cond     = 4'hE;
            bus.FlagW    = 2'b11;
            bus.ALUFlags = 4'(i + 1);
            bus.FlagPush = 1'b1;
            step();
        end
        check("fill_full", 32'(bus.StackFull), 32'h1);
        check("fill_no_err", 32'(bus.StackErr), 32'h0);
        check("fill_flags", 32'(bus.Flags), 32'h4);
        bus.FlagW = 2'b00;
        step();
        check("overflow_err", 32'(bus.StackErr), 32'h1);
        check("overflow_full", 32'(bus.StackFull), 32'h1);
        check("overflow_flags", 32'(bus.Flags), 32'h4);
        bus.FlagPush = 1'b0;
        bus.FlagPop  = 1'b1;
        step();
        check("lifo_pop0", 32'(bus.Flags), 32'h3);
        check("lifo_not_full", 32'(bus.StackFull), 32'h0);
        step();
        check("lifo_pop1", 32'(bus.Flags), 32'h2);
        step();
        check("lifo_pop2", 32'(bus.Flags), 32'h1);
        step();
        check("lifo_pop3", 32'(bus.Flags), 32'hA);
        check("lifo_empty", 32'(bus.StackEmpty), 32'h1);
        idle();

        // Pop from empty after reset
        pulse_reset();
        check("rst2_err", 32'(bus.StackErr), 32'h0);
        bus.FlagPop = 1'b1;
        step();
        check("underflow_err", 32'(bus.StackErr), 32'h1);
        check("underflow_flags", 32'(bus.Flags), 32'h0);
        check("underflow_empty", 32'(bus.StackEmpty), 32'h1);
        idle();

        // Push & pop together: count unchanged, FlagW still applies
        pulse_reset();
        bus.FlagPush = 1'b1;
        step();
        check("one_entry", 32'(bus.StackEmpty), 32'h0);
        check("one_entry_err", 32'(bus.StackErr), 32'h0);
        bus.FlagPop  = 1'b1;
        bus.Cond     = 4'hE;
        bus.FlagW    = 2'b11;
        bus.ALUFlags = 4'b0110;
        step();
        check("pushpop_err", 32'(bus.StackErr), 32'h1);
        check("pushpop_flags", 32'(bus.Flags), 32'h6);
        check("pushpop_not_empty", 32'(bus.StackEmpty), 32'h0);
        check("pushpop_not_full", 32'(bus.StackFull), 32'h0);
        idle();

        // Mid-operation async reset
        bus.Cond      = 4'hE;
        bus.CondLatch = 1'b1;
        step();
        bus.CondLatch = 1'b0;
        bus.RegW      = 1'b1;
        bus.NextPC    = 1'b1;
        check("pre_rst_q", 32'(bus.CondExQ), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_flags", 32'(bus.Flags), 32'h0);
        check("async_q", 32'(bus.CondExQ), 32'h0);
        check("async_regwrite", 32'(bus.RegWrite), 32'h0);
        check("async_pcwrite", 32'(bus.PCWrite), 32'h0);
        check("async_empty", 32'(bus.StackEmpty), 32'h1);
        check("async_err", 32'(bus.StackErr), 32'h0);
        reset = 1'b1;
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
